// File: rtl/phy_tx_serializer_if.sv
// rtl/phy_tx_serializer_if.sv - control and SRAM bus bundle for the UPDI transmit serializer
//
// Purpose: groups the start/status handshake, the frame SRAM read port and
// the serial line of phy_tx_serializer into one bundle.
// Signals:
//   ten        start strobe (sampled only while idle)
//   base_addr  SRAM address of the first frame
//   frame_cnt  number of frames to send
//   csb0       SRAM chip select, active-low
//   web0       SRAM write enable, active-low (held high, read-only)
//   addr0      SRAM address
//   i_data     SRAM read data, valid the cycle after csb0 is low
//   pwdata     serial transmit line, idle high
//   tend       one-cycle block-complete pulse
//   busy       high whenever the serializer is not idle
//   frame_err  sticky malformed-frame flag
// Modports: master = serializer side, slave = controller/SRAM side.
interface phy_tx_serializer_if;
  logic        ten;
  logic [6:0]  base_addr;
  logic [6:0]  frame_cnt;
  logic        csb0;
  logic        web0;
  logic [6:0]  addr0;
  logic [11:0] i_data;
  logic        pwdata;
  logic        tend;
  logic        busy;
  logic        frame_err;

  modport master (
    input  ten, base_addr, frame_cnt, i_data,
    output csb0, web0, addr0, pwdata, tend, busy, frame_err
  );

  modport slave (
    output ten, base_addr, frame_cnt, i_data,
    input  csb0, web0, addr0, pwdata, tend, busy, frame_err
  );
endinterface

// File: rtl/phy_tx_serializer.sv
// rtl/phy_tx_serializer.sv - UPDI PHY transmit serializer fed from the frame SRAM
//
// Purpose: on a start strobe, reads frame_cnt pre-formatted 12-bit line images
// from the frame SRAM starting at base_addr and shifts each one out LSB-first
// on pwdata, CLKS_PER_BIT clocks per bit, with a 2-cycle high gap per frame.
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   bus  phy_tx_serializer_if.master (start/status, SRAM read port, serial line)
// Parameters:
//   CLKS_PER_BIT  clocks per transmitted bit, 1..255
module phy_tx_serializer #(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  phy_tx_serializer_if.master        bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [7:0] BAUD_LAST = 8'(CLKS_PER_BIT - 1);

  state_t      state_q;
  // Bit 0 of the frame lives in pwdata_q; rest_q holds bits [11:1] still to go.
  logic [10:0] rest_q;
  logic [3:0]  bit_idx_q;
  logic [7:0]  baud_q;
  logic [6:0]  cur_addr_q;
  logic [6:0]  remain_q;
  logic [6:0]  addr0_q;
  logic        csb0_q;
  logic        pwdata_q;
  logic        tend_q;
  logic        busy_q;
  logic        frame_err_q;

  logic [6:0]  addr_inc_d;
  logic [6:0]  remain_dec_d;
  logic        word_bad_d;
  logic        baud_tc_d;

  assign addr_inc_d   = cur_addr_q + 7'd1;   // natural 7-bit wrap 127 -> 0
  assign remain_dec_d = remain_q - 7'd1;
  assign baud_tc_d    = (baud_q == BAUD_LAST);
  // Bad start bit, bad stop bits, or parity bit disagreeing with even parity of data.
  assign word_bad_d   = bus.i_data[0] | ~(&bus.i_data[11:10]) | (^bus.i_data[9:1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rest_q      <= '0;
      bit_idx_q   <= '0;
      baud_q      <= '0;
      cur_addr_q  <= '0;
      remain_q    <= '0;
      addr0_q     <= '0;
      csb0_q      <= 1'b1;
      pwdata_q    <= 1'b1;
      tend_q      <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      tend_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.ten) begin
            busy_q <= 1'b1;
            if (bus.frame_cnt != 7'd0) begin
              cur_addr_q  <= bus.base_addr;
              addr0_q     <= bus.base_addr;
              remain_q    <= bus.frame_cnt;
              frame_err_q <= 1'b0;
              csb0_q      <= 1'b0;
              state_q     <= FETCH;
            end else begin
              tend_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end

        FETCH: begin
          csb0_q  <= 1'b1;
          state_q <= LOAD;
        end

        LOAD: begin
          // Malformed words are flagged but still sent as-is.
          pwdata_q  <= bus.i_data[0];
          rest_q    <= bus.i_data[11:1];
          bit_idx_q <= 4'd0;
          baud_q    <= 8'd0;
          if (word_bad_d) begin
            frame_err_q <= 1'b1;
          end
          state_q <= SHIFT;
        end

        SHIFT: begin
          if (baud_tc_d) begin
            baud_q <= 8'd0;
            if (bit_idx_q == 4'd11) begin
              pwdata_q   <= 1'b1;
              cur_addr_q <= addr_inc_d;
              remain_q   <= remain_dec_d;
              if (remain_dec_d == 7'd0) begin
                tend_q  <= 1'b1;
                state_q <= DONE;
              end else begin
                addr0_q <= addr_inc_d;
                csb0_q  <= 1'b0;
                state_q <= FETCH;
              end
            end else begin
              pwdata_q  <= rest_q[0];
              rest_q    <= {1'b0, rest_q[10:1]};
              bit_idx_q <= bit_idx_q + 4'd1;
            end
          end else begin
            baud_q <= baud_q + 8'd1;
          end
        end

        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.csb0      = csb0_q;
  assign bus.web0      = 1'b1;
  assign bus.addr0     = addr0_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.tend      = tend_q;
  assign bus.busy      = busy_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_phy_tx_serializer.sv
// tb/tb_phy_tx_serializer.sv - directed table-driven bench for phy_tx_serializer
//
// Purpose: drives start strobes into two serializer instances (1 and 4 clocks
// per bit) backed by a synchronous-read frame SRAM model and checks SRAM
// reads, serial bit streams, tend timing, busy and frame_err.
// Ports: none (top-level bench).
module tb_phy_tx_serializer;

  typedef struct {
    int               base;
    int               cnt;
    logic [2:0][11:0] w;
    int               lat;
    int               err;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [11:0] mem [0:127];

  int n_checks;
  int n_fail;

  int rd_n;
  int rd_addr [0:7];
  int rd_k    [0:7];
  int tend_k;
  int tend_n;
  logic bits   [0:127];
  logic busy_s [0:127];
  logic err_s  [0:127];

  vec_t vt [0:4];

  phy_tx_serializer_if if1 ();
  phy_tx_serializer_if if4 ();

  phy_tx_serializer #(.CLKS_PER_BIT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
  phy_tx_serializer #(.CLKS_PER_BIT(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!if1.csb0) if1.i_data <= mem[if1.addr0];
    if (!if4.csb0) if4.i_data <= mem[if4.addr0];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Start if1 and record every cycle of the window (sampled at negedge).
  task automatic run1(input int base, input int cnt, input int win, input bit poke);
    @(negedge clk);
    if1.base_addr = 7'(base);
    if1.frame_cnt = 7'(cnt);
    if1.ten = 1'b1;
    @(negedge clk);
    if1.ten = 1'b0;
    rd_n = 0; tend_n = 0; tend_k = -1;
    for (int k = 0; k < win; k++) begin
      bits[k]   = if1.pwdata;
      busy_s[k] = if1.busy;
      err_s[k]  = if1.frame_err;
      if (!if1.csb0) begin
        if (rd_n < 8) begin
          rd_addr[rd_n] = int'(if1.addr0);
          rd_k[rd_n] = k;
        end
        rd_n++;
      end
      if (if1.tend) begin
        if (tend_k < 0) tend_k = k;
        tend_n++;
      end
      if (poke && (k == 5 || k == 9)) begin
        if1.ten = 1'b1;
        if1.base_addr = 7'd40;
        if1.frame_cnt = 7'd1;
      end else begin
        if1.ten = 1'b0;
      end
      @(negedge clk);
    end
    if1.ten = 1'b0;
  endtask

  task automatic check_run(input vec_t v);
    int mism;
    int ti;
    chk("read_count", rd_n, v.cnt);
    for (int f = 0; f < v.cnt; f++) begin
      chk("read_addr", rd_addr[f], (v.base + f) % 128);
      chk("read_cycle", rd_k[f], f * 14);
      mism = 0;
      if (bits[f * 14] !== 1'b1) mism++;
      if (bits[f * 14 + 1] !== 1'b1) mism++;
      for (int b = 0; b < 12; b++)
        if (bits[2 + f * 14 + b] !== v.w[f][b]) mism++;
      chk("bit_stream", mism, 0);
    end
    chk("tend_cycle", tend_k, v.lat);
    chk("tend_count", tend_n, 1);
    ti = (tend_k < 0) ? 0 : tend_k;
    chk("busy_at_tend", busy_s[ti], 1);
    chk("busy_after_tend", busy_s[ti + 1], 0);
    chk("err_at_start", err_s[0], 0);
    if (v.cnt > 0) chk("err_after_load", err_s[2], v.err);
    chk("err_after_tend", err_s[ti + 1], v.err);
  endtask

  initial begin
    vec_t vb;
    int mism, rd, tk, tn;
    n_checks = 0;
    n_fail = 0;
    for (int i = 0; i < 128; i++) mem[i] = 12'hC00;

    vt[0] = '{5,   1, {12'h000, 12'h000, 12'hCAA}, 14, 0};
    vt[1] = '{126, 3, {12'hDFE, 12'hC00, 12'hCAA}, 42, 0};
    vt[2] = '{10,  1, {12'h000, 12'h000, 12'hEAA}, 14, 1};
    vt[3] = '{20,  2, {12'h000, 12'hDFE, 12'hC00}, 28, 0};
    vt[4] = '{0,   0, {12'h000, 12'h000, 12'h000}, 0,  0};

    rst = 1'b1;
    if1.ten = 1'b0; if1.base_addr = '0; if1.frame_cnt = '0;
    if4.ten = 1'b0; if4.base_addr = '0; if4.frame_cnt = '0;
    repeat (3) @(negedge clk);
    chk("rst_pwdata", if1.pwdata, 1);
    chk("rst_csb0", if1.csb0, 1);
    chk("rst_web0", if1.web0, 1);
    chk("rst_addr0", if1.addr0, 0);
    chk("rst_tend", if1.tend, 0);
    chk("rst_busy", if1.busy, 0);
    chk("rst_frame_err", if1.frame_err, 0);
    rst = 1'b0;
    @(negedge clk);

    // Explicit line image of 0xCAA on the first frame.
    mem[5] = 12'hCAA;
    run1(5, 1, 30, 1'b0);
    begin
      logic [11:0] pat;
      logic [11:0] got;
      pat = 12'b110010101010;
      for (int b = 0; b < 12; b++) got[b] = bits[2 + b];
      chk("single_pattern", got, pat);
    end

    for (int i = 0; i < 5; i++) begin
      for (int f = 0; f < vt[i].cnt; f++) mem[(vt[i].base + f) % 128] = vt[i].w[f];
      run1(vt[i].base, vt[i].cnt, vt[i].lat + 16, 1'b0);
      check_run(vt[i]);
    end

    // ten pulses while shifting must not restart or add reads.
    mem[30] = 12'hCAA;
    vb = '{30, 1, {12'h000, 12'h000, 12'hCAA}, 14, 0};
    run1(30, 1, 30, 1'b1);
    check_run(vb);

    // Baud divider of 4 on the second instance.
    mem[5] = 12'hCAA;
    @(negedge clk);
    if4.base_addr = 7'd5; if4.frame_cnt = 7'd1; if4.ten = 1'b1;
    @(negedge clk);
    if4.ten = 1'b0;
    mism = 0; rd = 0; tk = -1;
    for (int k = 0; k < 66; k++) begin
      if (k >= 2 && k < 50) begin
        if (if4.pwdata !== vb.w[0][(k - 2) / 4]) mism++;
      end else if (k < 2) begin
        if (if4.pwdata !== 1'b1) mism++;
      end
      if (!if4.csb0) rd++;
      if (if4.tend && tk < 0) tk = k;
      @(negedge clk);
    end
    chk("baud4_stream", mism, 0);
    chk("baud4_reads", rd, 1);
    chk("baud4_tend_cycle", tk, 50);

    // Reset during bit 6 of a frame.
    @(negedge clk);
    if1.base_addr = 7'd5; if1.frame_cnt = 7'd1; if1.ten = 1'b1;
    @(negedge clk);
    if1.ten = 1'b0;
    repeat (8) @(negedge clk);
    chk("mid_bit6_low", if1.pwdata, 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_pwdata", if1.pwdata, 1);
    chk("mid_rst_csb0", if1.csb0, 1);
    chk("mid_rst_busy", if1.busy, 0);
    tn = 0;
    repeat (3) begin
      @(negedge clk);
      if (if1.tend) tn++;
    end
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (if1.tend) tn++;
    end
    chk("mid_rst_no_tend", tn, 0);
    vb = '{5, 1, {12'h000, 12'h000, 12'hCAA}, 14, 0};
    run1(5, 1, 30, 1'b0);
    check_run(vb);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/phy_tx_serializer.md
# phy_tx_serializer

UPDI physical-layer transmit serializer. On a start strobe it reads a block of pre-formatted 12-bit UPDI/UART frames from the PHY frame SRAM and shifts each one out LSB-first on the single-wire transmit line `pwdata`. It is the transmit counterpart of the PHY receive loader and shares the same SRAM port style (`csb0`, `web0`, `addr0`). Frames are stored in SRAM as complete line images: start bit, 8 data bits, even parity, 2 stop bits.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 1: clock cycles per transmitted bit; legal range 1..255.

Ports:
- `clk`  in  1  system clock; all state is on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `ten`  in  1  transmit enable strobe, sampled only in IDLE.
- `base_addr`  in  7  SRAM address of the first frame; latched on start.
- `frame_cnt`  in  7  number of frames to send; latched on start.
- `csb0`  out  1  SRAM chip select, active-low.
- `web0`  out  1  SRAM write enable, active-low; this block holds it at 1 (read-only).
- `addr0`  out  7  SRAM address.
- `i_data`  in  12  SRAM read data, valid one cycle after the `csb0`=0 cycle.
- `pwdata`  out  1  serial transmit line, idle high, registered.
- `tend`  out  1  one-cycle pulse when the block transfer completes.
- `busy`  out  1  high in every state except IDLE.
- `frame_err`  out  1  sticky flag for a malformed frame word; cleared on each accepted start.

## Operation
- Frame word layout, transmitted bit 0 first:
  - [0] start bit, must be 0.
  - [8:1] data, LSB first.
  - [9] even parity over [8:1].
  - [11:10] stop bits, must be 11.
- FSM states: IDLE, FETCH, LOAD, SHIFT, DONE.
- **IDLE**
  - `ten`=1 and `frame_cnt`≠0: latch `base_addr` into the address register and `frame_cnt` into the remaining counter, clear `frame_err`, go to FETCH.
  - `ten`=1 and `frame_cnt`=0: go to DONE with no SRAM access.
- **FETCH**: `csb0`=0, `addr0`=current address. Always go to LOAD.
- **LOAD**: capture `i_data` into the 12-bit shift register, set bit index to 0 and baud counter to 0, go to SHIFT.
  - `frame_err` sets if the captured word has any of: [0]≠0, [11:10]≠11, or odd XOR over [9:1].
  - A malformed word is still transmitted unchanged.
- **SHIFT**
  - `pwdata` = shift register bit 0.
  - The baud counter counts 0..CLKS_PER_BIT-1; at terminal count the register shifts right and the bit index increments.
  - After bit 11 completes: increment the address (7-bit wrap, 127→0) and decrement the remaining counter.
  - Remaining count becomes 0 → DONE; otherwise → FETCH.
- **DONE**: `tend`=1 for exactly one cycle, then IDLE.
- `ten` outside IDLE is ignored; there is no queuing.
- `pwdata`=1 in IDLE, FETCH, LOAD and DONE.
- `csb0`=1 in every state except FETCH. `web0`=1 always.
- `addr0` holds the last driven address when not in FETCH.

## Timing
- Reset values: `pwdata`=1, `csb0`=1, `web0`=1, `addr0`=0, `tend`=0, `busy`=0, `frame_err`=0, FSM=IDLE.
- Reset asserted mid-frame forces `pwdata` high immediately (asynchronous); the transfer is abandoned and `tend` is not pulsed.
- `ten` sampled at edge E0:
  - FETCH during E0..E1.
  - LOAD during E1..E2.
  - Start bit on `pwdata` from E2 + register delay.
- Each bit lasts exactly CLKS_PER_BIT cycles; one frame occupies 12·CLKS_PER_BIT cycles.
- Inter-frame gap: 2 idle-high cycles (FETCH + LOAD). Frame period = 12·CLKS_PER_BIT + 2.
- `tend` asserts in the cycle after the last stop-bit cycle. `busy` falls with the exit from DONE.
- `frame_cnt`=0 start: `tend` pulses in the cycle after the `ten` edge; `busy`=1 for that one cycle.
- Total latency for N frames, from the `ten` edge to `tend` high: N·(12·CLKS_PER_BIT+2) cycles.

## Test plan
- **Single frame**, CLKS_PER_BIT=1, base=5, cnt=1, SRAM[5]=0xCAA (data 0x55):
  - exactly one `csb0` low cycle, with `addr0`=5;
  - `pwdata` = 0,1,0,1,0,1,0,1,0,0,1,1 on consecutive cycles starting 2 cycles after `ten`;
  - `tend` pulses once; `frame_err`=0.
- **Multi-frame wrap**, base=126, cnt=3, SRAM[126,127,0]=0xCAA,0xC00,0xDFE:
  - reads at 126, 127, 0, each preceded by a 2-cycle high gap;
  - all three bit streams correct;
  - `tend` 42 cycles after the `ten` edge.
- **Baud divider**, CLKS_PER_BIT=4, one frame 0xCAA:
  - each bit held 4 cycles;
  - `tend` 50 cycles after the `ten` edge.
- **Malformed word**, SRAM word 0xEAA (parity bit wrong):
  - transmitted unchanged;
  - `frame_err`=1 from the LOAD edge onward and after `tend`;
  - the next `ten` clears it.
- **Busy rejection and zero count**:
  - `ten` pulses while SHIFT is active → no extra reads and no restart;
  - `ten` with cnt=0 → `tend` next cycle, `csb0` never low.
- **Reset mid-frame**, `rst` asserted during bit 6:
  - `pwdata`=1, `csb0`=1, `busy`=0 immediately, no `tend`;
  - a new `ten` after release transmits normally.
